// File: rtl/shim_scatter.sv
// shim_scatter: captures one aligned vector on VALID_IN and hands each lane
// to its own consumer over an independent valid/ready handshake. DONE_OUT
// pulses for one cycle once every lane has accepted. A VALID_IN arriving
// while busy is dropped and latched in the sticky DROP_OUT flag.
// Optional build macro SHIM_SCATTER_TIMEOUT_EN adds a SCATTER-state cycle
// budget that abandons the vector and pulses TIMEOUT_OUT.
module shim_scatter #(
  parameter int NUM_OUTPUTS    = 1,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [NUM_OUTPUTS-1:0][WIDTH-1:0]      VALUES_IN,
  input  logic                                   VALID_IN,
  output logic                                   READY_OUT,
  output logic [NUM_OUTPUTS-1:0][WIDTH-1:0]      VALUES_OUT,
  output logic [NUM_OUTPUTS-1:0]                 VALIDS_OUT,
  input  logic [NUM_OUTPUTS-1:0]                 READYS_IN,
  output logic                                   DONE_OUT,
  output logic                                   DROP_OUT,
  output logic                                   TIMEOUT_OUT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCATTER = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]                            state_q, state_d;
  logic [NUM_OUTPUTS-1:0]                pending_q, pending_d;
  logic [NUM_OUTPUTS-1:0][WIDTH-1:0]     values_q, values_d;
  logic                                  drop_q, drop_d;

`ifdef SHIM_SCATTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Next-state, pending mask, capture and drop detection
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    values_d  = values_q;
    drop_d    = drop_q;
`ifdef SHIM_SCATTER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          values_d  = VALUES_IN;
          pending_d = '1;
          state_d   = SCATTER;
`ifdef SHIM_SCATTER_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      SCATTER: begin
        // A ready on an already-accepted lane cannot re-set anything: only clears.
        pending_d = pending_q & ~READYS_IN;
        if (VALID_IN) drop_d = 1'b1;
        if (pending_d == '0) begin
          state_d = DONE;
        end
`ifdef SHIM_SCATTER_TIMEOUT_EN
        // Final-cycle acceptances win: timeout only if lanes remain after them.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          pending_d = '0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      DONE: begin
        if (VALID_IN) drop_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      values_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      values_q  <= values_d;
      drop_q    <= drop_d;
    end
  end

`ifdef SHIM_SCATTER_TIMEOUT_EN
  // SCATTER cycle budget counter and registered abort pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT_OUT = timeout_q;
`else
  // Budget parameter is inert without the timeout build; output stays low.
  assign TIMEOUT_OUT = (TIMEOUT_CYCLES > 0) && 1'b0;
`endif

  assign READY_OUT  = (state_q == IDLE);
  assign DONE_OUT   = (state_q == DONE);
  assign VALIDS_OUT = pending_q;
  assign VALUES_OUT = values_q;
  assign DROP_OUT   = drop_q;

endmodule

// File: tb/tb_shim_scatter.sv
// Directed self-checking bench for shim_scatter (4 lanes x 8 bits).
// Timeout scenarios run when SHIM_SCATTER_TIMEOUT_EN is defined; otherwise
// an indefinite-wait scenario is exercised instead.
module tb_shim_scatter;

  logic            clk;
  logic            rst;
  logic [3:0][7:0] values_in;
  logic            valid_in;
  logic            ready_out;
  logic [3:0][7:0] values_out;
  logic [3:0]      valids_out;
  logic [3:0]      readys_in;
  logic            done_out;
  logic            drop_out;
  logic            timeout_out;

  int total = 0;
  int bad   = 0;

  shim_scatter #(
    .NUM_OUTPUTS(4),
    .WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .VALUES_IN(values_in),
    .VALID_IN(valid_in),
    .READY_OUT(ready_out),
    .VALUES_OUT(values_out),
    .VALIDS_OUT(valids_out),
    .READYS_IN(readys_in),
    .DONE_OUT(done_out),
    .DROP_OUT(drop_out),
    .TIMEOUT_OUT(timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {1,-2,3,-4} and {9,9,9,9} as packed 8-bit lanes
  localparam logic [31:0] V1 = 32'h01FE03FC;
  localparam logic [31:0] V9 = 32'h09090909;

  logic [3:0] rdy_tab [10];
  logic [3:0] vld_tab [10];

  initial begin
    rdy_tab[0] = 4'b0000; vld_tab[0] = 4'b0000;
    rdy_tab[1] = 4'b0001; vld_tab[1] = 4'b1111;
    rdy_tab[2] = 4'b0010; vld_tab[2] = 4'b1110;
    rdy_tab[3] = 4'b0000; vld_tab[3] = 4'b1100;
    rdy_tab[4] = 4'b0100; vld_tab[4] = 4'b1100;
    rdy_tab[5] = 4'b0000; vld_tab[5] = 4'b1000;
    rdy_tab[6] = 4'b0000; vld_tab[6] = 4'b1000;
    rdy_tab[7] = 4'b1000; vld_tab[7] = 4'b1000;
    rdy_tab[8] = 4'b0000; vld_tab[8] = 4'b0000;
    rdy_tab[9] = 4'b0000; vld_tab[9] = 4'b0000;

    rst       = 1'b1;
    valid_in  = 1'b0;
    values_in = '0;
    readys_in = '0;
    #3;
    chk("rst_valids",  32'(valids_out), 32'h0);
    chk("rst_values",  values_out, 32'h0);
    chk("rst_done",    32'(done_out), 32'h0);
    chk("rst_drop",    32'(drop_out), 32'h0);
    chk("rst_timeout", 32'(timeout_out), 32'h0);
    chk("rst_ready",   32'(ready_out), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Test 1: all lanes ready, minimum turnaround
    chk("t1_ready_c0", 32'(ready_out), 32'h1);
    valid_in  = 1'b1;
    values_in = V1;
    readys_in = 4'b1111;
    tick();
    valid_in  = 1'b0;
    values_in = '0;
    chk("t1_valids_c1", 32'(valids_out), 32'hF);
    chk("t1_values_c1", values_out, V1);
    chk("t1_ready_c1",  32'(ready_out), 32'h0);
    chk("t1_done_c1",   32'(done_out), 32'h0);
    tick();
    chk("t1_valids_c2", 32'(valids_out), 32'h0);
    chk("t1_done_c2",   32'(done_out), 32'h1);
    chk("t1_ready_c2",  32'(ready_out), 32'h0);
    tick();
    readys_in = '0;
    chk("t1_done_c3",   32'(done_out), 32'h0);
    chk("t1_ready_c3",  32'(ready_out), 32'h1);
    chk("t1_values_c3", values_out, V1);

    // Tests 2 and 3: staggered readies with a dropped vector at cycle 3
    valid_in  = 1'b1;
    values_in = V1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      valid_in  = (c == 3);
      values_in = (c == 3) ? V9 : V1;
      readys_in = rdy_tab[c];
      chk($sformatf("t2_valids_c%0d", c), 32'(valids_out), 32'(vld_tab[c]));
      chk($sformatf("t2_done_c%0d", c),   32'(done_out),  32'(c == 8));
      chk($sformatf("t2_ready_c%0d", c),  32'(ready_out), 32'(c == 9));
      chk($sformatf("t3_drop_c%0d", c),   32'(drop_out),  32'(c >= 4));
      chk($sformatf("t3_values_c%0d", c), values_out, V1);
    end

    // Test 4: asynchronous reset in SCATTER with lanes 1-3 pending
    valid_in  = 1'b1;
    values_in = V1;
    readys_in = '0;
    tick();
    valid_in  = 1'b0;
    readys_in = 4'b0001;
    tick();
    readys_in = '0;
    chk("t4_valids_pre", 32'(valids_out), 32'hE);
    #3;
    rst = 1'b1;
    #1;
    chk("t4_valids_rst", 32'(valids_out), 32'h0);
    chk("t4_values_rst", values_out, 32'h0);
    chk("t4_drop_rst",   32'(drop_out), 32'h0);
    chk("t4_done_rst",   32'(done_out), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t4_done_after%0d", c),   32'(done_out), 32'h0);
      chk($sformatf("t4_ready_after%0d", c),  32'(ready_out), 32'h1);
      chk($sformatf("t4_valids_after%0d", c), 32'(valids_out), 32'h0);
    end

`ifdef SHIM_SCATTER_TIMEOUT_EN
    // Test 5: lane 2 never ready, budget expires
    valid_in  = 1'b1;
    values_in = V1;
    readys_in = 4'b1011;
    for (int c = 1; c <= 18; c++) begin
      tick();
      valid_in = 1'b0;
      chk($sformatf("t5_timeout_c%0d", c), 32'(timeout_out), 32'(c == 17));
      chk($sformatf("t5_done_c%0d", c),    32'(done_out), 32'h0);
      chk($sformatf("t5_ready_c%0d", c),   32'(ready_out), 32'(c >= 17));
      chk($sformatf("t5_valids_c%0d", c),  32'(valids_out),
          (c == 1) ? 32'hF : ((c <= 16) ? 32'h4 : 32'h0));
    end

    // Test 6: last lane accepts on the final budget cycle
    valid_in  = 1'b1;
    values_in = V1;
    readys_in = '0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      valid_in  = 1'b0;
      readys_in = (c == 1) ? 4'b1011 : ((c == 16) ? 4'b0100 : 4'b0000);
      chk($sformatf("t6_timeout_c%0d", c), 32'(timeout_out), 32'h0);
      chk($sformatf("t6_done_c%0d", c),    32'(done_out), 32'(c == 17));
      chk($sformatf("t6_ready_c%0d", c),   32'(ready_out), 32'(c >= 18));
    end
`else
    // No budget: SCATTER waits indefinitely, then completes normally
    valid_in  = 1'b1;
    values_in = V1;
    readys_in = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      valid_in = 1'b0;
      chk($sformatf("nt_valids_c%0d", c),  32'(valids_out), 32'hF);
      chk($sformatf("nt_timeout_c%0d", c), 32'(timeout_out), 32'h0);
      chk($sformatf("nt_done_c%0d", c),    32'(done_out), 32'h0);
      chk($sformatf("nt_ready_c%0d", c),   32'(ready_out), 32'h0);
    end
    readys_in = 4'b1111;
    tick();
    readys_in = '0;
    chk("nt_done_final",   32'(done_out), 32'h1);
    chk("nt_valids_final", 32'(valids_out), 32'h0);
    tick();
    chk("nt_ready_final",  32'(ready_out), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
